pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic buffer placed between adjacent NPC pipeline stages (IFU→IDU, IDU→EXU, EXU→WBU). It replaces the single-bit valid/ready registers between stages with a DEPTH-entry FIFO carrying a DATA_W-bit stage payload, such as PC, instruction and decoded controls. A flush input discards all in-flight entries on a branch or CSR redirect, so upstream stages can run ahead of a stalled downstream stage without losing or duplicating instructions.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (≥1)
- DEPTH, 2, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all stored entries this cycle
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  buffer accepts in_data this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  out_data holds the oldest stored entry
- out_ready  input  1  downstream consumes the oldest entry this cycle
- out_data  output  DATA_W  oldest stored entry
- count  output  CNT_W  current occupancy, 0..DEPTH
- perf_stall  output  32  upstream stall cycles (only with PIPE_STAGE_BUF_PERF_EN)
- perf_xfer  output  32  accepted pushes (only with PIPE_STAGE_BUF_PERF_EN)

## Operation
- Storage: DEPTH×DATA_W array, write pointer wp, read pointer rp (log2(DEPTH) bits each, natural wrap at DEPTH), and occupancy count.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It depends only on registered state. There is no combinational path from out_ready; when full, a same-cycle pop does not admit a push.
- out_valid = (count != 0). out_data = mem[rp]. When out_valid=0, out_data is don't-care but must not be X after reset (mem is cleared to 0 on reset).
- push: mem[wp] ← in_data, wp ← wp+1. pop: rp ← rp+1. count ← count + push − pop. Simultaneous push and pop leaves count unchanged.
- flush has priority over push and pop. wp, rp and count ← 0 and no entry is consumed. in_valid and out_ready are ignored that cycle. Memory contents are left stale.
- Ordering is strict FIFO; each accepted entry is presented exactly once unless flushed.
- Reset (asynchronous, any time, including mid-transfer): wp=rp=count=0, mem cleared, out_valid=0, in_ready=1, perf counters=0. Outputs take reset values immediately on rst assertion. Operation resumes on the first clk edge after rst deasserts.

## Timing
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N, and can pop at edge N+1. There is no same-cycle in→out bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full boundary: count=DEPTH gives in_ready=0. After a pop at edge N, in_ready=1 from edge N onward.
- Empty boundary: count=0 gives out_valid=0, and out_ready is ignored.
- Flush at edge N: count=0, out_valid=0 and in_ready=1 after edge N.
- Upstream must hold in_valid/in_data stable while in_valid & ~in_ready. This is a protocol requirement and is checked by a bench assertion, not by the RTL.

## Configuration
- PIPE_STAGE_BUF_PERF_EN defined:
  - perf_stall and perf_xfer ports exist.
  - perf_stall increments each cycle with in_valid & ~in_ready & ~flush.
  - perf_xfer increments on every push.
  - Both counters saturate at 32'hFFFF_FFFF, are unaffected by flush, and are cleared only by rst.
- PIPE_STAGE_BUF_PERF_EN undefined: the ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset and fill, DEPTH=4:
  - Stimulus: assert rst, then push 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - Response: during reset, in_ready=1, out_valid=0, count=0. After the 4th push, count=4 and in_ready=0. A 5th offer of 0x55 is not accepted.
- Drain order:
  - Stimulus: from full, hold out_ready=1.
  - Response: out_data is 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Then out_valid=0 and count=0.
- Streaming with wrap:
  - Stimulus: 20 back-to-back entries 0..19 with in_valid=out_ready=1, DEPTH=2.
  - Response: all 20 values are received in order, count stays ≤1 after warm-up, and pointers wrap without loss.
- Flush priority:
  - Stimulus: count=3, assert flush, in_valid=1 and out_ready=1 in the same cycle.
  - Response: next cycle count=0 and out_valid=0. Neither the incoming entry nor the head entry is delivered.
- Async reset mid-transfer:
  - Stimulus: assert rst between edges with count=2.
  - Response: out_valid=0 and count=0 before the next edge. The first entry pushed after deassert is the first entry out.
- Perf counters (PIPE_STAGE_BUF_PERF_EN):
  - Stimulus: fill DEPTH=2, then hold in_valid=1 and out_ready=0 for 5 cycles.
  - Response: perf_xfer=2 and perf_stall=5. A later flush leaves both values unchanged.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- elastic FIFO buffer between adjacent pipeline stages.
//
// Holds up to DEPTH stage payloads of DATA_W bits so an upstream stage can run
// ahead of a stalled downstream stage. A flush discards every in-flight entry
// on a branch or CSR redirect.
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   DEPTH   number of entries, power of two, >= 2
//   CNT_W   occupancy counter width (derived, leave at default)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   flush       discard all stored entries this cycle (beats push and pop)
//   in_valid    upstream offers in_data
//   in_ready    buffer can accept (registered state only: count != DEPTH)
//   in_data     upstream payload
//   out_valid   out_data holds the oldest entry (count != 0)
//   out_ready   downstream consumes the oldest entry this cycle
//   out_data    oldest stored entry
//   count       current occupancy, 0..DEPTH
//   perf_stall  upstream stall cycles   (PIPE_STAGE_BUF_PERF_EN only)
//   perf_xfer   accepted pushes         (PIPE_STAGE_BUF_PERF_EN only)
//
// Optional feature macro: PIPE_STAGE_BUF_PERF_EN adds saturating performance
// counters that only rst clears.

module pipe_stage_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_xfer
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    // Handshake outputs come only from registered occupancy, so a pop while
    // full never opens the input in the same cycle.
    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rp_q];
    assign count     = cnt_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            // Flush leaves stored payloads stale; only the pointers move.
            if (push) begin
                mem_q[wp_q] <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] xfer_q, xfer_d;

    always_comb begin
        stall_d = stall_q;
        xfer_d  = xfer_q;
        if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (push && (xfer_q != '1)) begin
            xfer_d = xfer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            xfer_q  <= '0;
        end else begin
            stall_q <= stall_d;
            xfer_q  <= xfer_d;
        end
    end

    assign perf_stall = stall_q;
    assign perf_xfer  = xfer_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: instance A (DEPTH=4) runs a directed vector table
// covering fill, full boundary, drain order, empty boundary and flush; instance
// B (DEPTH=2) covers streaming with wrap and the optional perf counters.
// Both share clk and rst, so the async reset sequence exercises both.

module tb_pipe_stage_buf;

    logic clk;
    logic rst;

    // Instance A: DEPTH=4
    logic       a_fl, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_din, a_od;
    logic [2:0] a_count;

    // Instance B: DEPTH=2
    logic       b_fl, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_din, b_od;
    logic [1:0] b_count;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] a_pstall, a_pxfer, b_pstall, b_pxfer;
`endif

    int n_tests;
    int n_fail;

    pipe_stage_buf #(.DATA_W(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_din),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .count(a_count)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .perf_stall(a_pstall), .perf_xfer(a_pxfer)
`endif
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_din),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .count(b_count)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .perf_stall(b_pstall), .perf_xfer(b_pxfer)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream protocol: a stalled offer must be held with stable data.
    property p_hold_a;
        @(posedge clk) disable iff (rst)
        (a_iv && !a_ir && !a_fl) |=> (a_iv && $stable(a_din));
    endproperty
    property p_hold_b;
        @(posedge clk) disable iff (rst)
        (b_iv && !b_ir && !b_fl) |=> (b_iv && $stable(b_din));
    endproperty
    a_hold_a: assert property (p_hold_a);
    a_hold_b: assert property (p_hold_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       chk_od;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    initial begin
        int tx;
        int rx;

        n_tests = 0;
        n_fail  = 0;

        //            fl  iv  din    or   ir  ov  od     cnt   chk_od
        tv[0]  = '{1'b0,1'b1,8'h11,1'b0, 1'b1,1'b1,8'h11,3'd1,1'b1};
        tv[1]  = '{1'b0,1'b1,8'h22,1'b0, 1'b1,1'b1,8'h11,3'd2,1'b1};
        tv[2]  = '{1'b0,1'b1,8'h33,1'b0, 1'b1,1'b1,8'h11,3'd3,1'b1};
        tv[3]  = '{1'b0,1'b1,8'h44,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        // full: 0x55 is offered but not taken
        tv[4]  = '{1'b0,1'b1,8'h55,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        // full + pop: pop happens, push still refused that cycle
        tv[5]  = '{1'b0,1'b1,8'h55,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        tv[6]  = '{1'b0,1'b1,8'h55,1'b1, 1'b1,1'b1,8'h22,3'd3,1'b1};
        // simultaneous push 0x55 and pop 0x22
        tv[7]  = '{1'b0,1'b1,8'h55,1'b1, 1'b1,1'b1,8'h33,3'd3,1'b1};
        tv[8]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h44,3'd2,1'b1};
        tv[9]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h55,3'd1,1'b1};
        tv[10] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,3'd0,1'b0};
        // empty: out_ready ignored
        tv[11] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,3'd0,1'b0};
        tv[12] = '{1'b0,1'b1,8'hA1,1'b0, 1'b1,1'b1,8'hA1,3'd1,1'b1};
        tv[13] = '{1'b0,1'b1,8'hA2,1'b0, 1'b1,1'b1,8'hA1,3'd2,1'b1};
        tv[14] = '{1'b0,1'b1,8'hA3,1'b0, 1'b1,1'b1,8'hA1,3'd3,1'b1};
        tv[15] = '{1'b0,1'b1,8'hA4,1'b0, 1'b0,1'b1,8'hA1,3'd4,1'b1};
        tv[16] = '{1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b1,8'hA2,3'd3,1'b1};
        tv[17] = '{1'b0,1'b1,8'hA5,1'b0, 1'b0,1'b1,8'hA2,3'd4,1'b1};
        tv[18] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'hA3,3'd3,1'b1};
        // flush with push and pop offered: nothing delivered, nothing stored
        tv[19] = '{1'b1,1'b1,8'h66,1'b1, 1'b1,1'b0,8'h00,3'd0,1'b0};
        tv[20] = '{1'b0,1'b1,8'h77,1'b0, 1'b1,1'b1,8'h77,3'd1,1'b1};
        tv[21] = '{1'b0,1'b1,8'h88,1'b1, 1'b1,1'b1,8'h88,3'd1,1'b1};

        // tv[5] duplicates tv[4] (stall held one more cycle) before the pop.

        rst = 1'b1;
        a_fl = 0; a_iv = 0; a_or = 0; a_din = '0;
        b_fl = 0; b_iv = 0; b_or = 0; b_din = '0;
        #3;
        chk("rst_a_in_ready", 32'(a_ir), 32'd1);
        chk("rst_a_out_valid", 32'(a_ov), 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_a_out_data", 32'(a_od), 32'd0);
        chk("rst_b_in_ready", 32'(b_ir), 32'd1);
        chk("rst_b_count", 32'(b_count), 32'd0);
`ifdef PIPE_STAGE_BUF_PERF_EN
        chk("rst_perf_stall", b_pstall, 32'd0);
        chk("rst_perf_xfer", b_pxfer, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table on instance A ----
        for (int i = 0; i < NV; i++) begin
            a_fl  = tv[i].fl;
            a_iv  = tv[i].iv;
            a_din = tv[i].din;
            a_or  = tv[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(a_ir), 32'(tv[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(a_ov), 32'(tv[i].e_ov));
            chk($sformatf("vec%0d_count", i), 32'(a_count), 32'(tv[i].e_cnt));
            if (tv[i].chk_od)
                chk($sformatf("vec%0d_out_data", i), 32'(a_od), 32'(tv[i].e_od));
        end
        a_fl = 0; a_iv = 0; a_or = 1;
        @(posedge clk); #1;
        a_or = 0;
        chk("drain_end_count", 32'(a_count), 32'd0);

        // ---- streaming with wrap on instance B (DEPTH=2) ----
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 100 && rx < 20; cyc++) begin
            b_iv  = (tx < 20);
            b_din = 8'(tx);
            b_or  = 1'b1;
            if (b_ov) begin
                chk("stream_data", 32'(b_od), 32'(rx));
                rx++;
            end
            if (b_iv && b_ir) tx++;
            @(posedge clk); #1;
            if (cyc >= 1)
                chk("stream_count_le1", 32'(b_count <= 2'd1), 32'd1);
        end
        b_iv = 0; b_or = 0;
        chk("stream_total", 32'(rx), 32'd20);
        chk("stream_empty", 32'(b_ov), 32'd0);

        // ---- async reset mid-transfer on instance A ----
        a_iv = 1; a_din = 8'hC1;
        @(posedge clk); #1;
        a_din = 8'hC2;
        @(posedge clk); #1;
        a_iv = 0;
        chk("pre_rst_count", 32'(a_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(a_ov), 32'd0);
        chk("async_rst_count", 32'(a_count), 32'd0);
        chk("async_rst_in_ready", 32'(a_ir), 32'd1);
        #1 rst = 1'b0;
        a_iv = 1; a_din = 8'hD1;
        @(posedge clk); #1;
        a_din = 8'hD2;
        @(posedge clk); #1;
        a_iv = 0;
        chk("post_rst_first_out", 32'(a_od), 32'hD1);
        chk("post_rst_count", 32'(a_count), 32'd2);

`ifdef PIPE_STAGE_BUF_PERF_EN
        // ---- perf counters on instance B (reset above) ----
        b_iv = 1; b_din = 8'hE1;
        @(posedge clk); #1;
        b_din = 8'hE2;
        @(posedge clk); #1;
        b_din = 8'hE3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("perf_xfer", b_pxfer, 32'd2);
        chk("perf_stall", b_pstall, 32'd5);
        b_fl = 1;
        @(posedge clk); #1;
        b_fl = 0; b_iv = 0;
        chk("perf_flush_count", 32'(b_count), 32'd0);
        chk("perf_xfer_after_flush", b_pxfer, 32'd2);
        chk("perf_stall_after_flush", b_pstall, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
